// File: rtl/ssd1306_spi4_ctrl.sv
// rtl/ssd1306_spi4_ctrl.sv - SSD1306 4-wire SPI receiver, command decoder and write-event FIFO
// Oversamples the SPI pins, decodes a command subset and queues GDDRAM writes as (col, page, data) events.
module ssd1306_spi4_ctrl #(
  parameter int DISP_WIDTH  = 128,
  parameter int DISP_HEIGHT = 64,
  parameter int FIFO_DEPTH  = 4,
  localparam int PAGES = DISP_HEIGHT / 8,
  localparam int CW    = $clog2(DISP_WIDTH),
  localparam int PW    = (PAGES > 1) ? $clog2(PAGES) : 1,
  localparam int AW    = $clog2(FIFO_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_in,
  input  logic          cs_in,
  input  logic          sck_i,
  input  logic          sdi_i,
  input  logic          dc_i,
  output logic          wr_valid_o,
  input  logic          wr_ready_i,
  output logic [CW-1:0] wr_col_o,
  output logic [PW-1:0] wr_page_o,
  output logic [7:0]    wr_data_o,
  output logic          disp_on_o,
  output logic          inverse_o,
  output logic          entire_on_o,
  output logic          flip_x_o,
  output logic          flip_y_o,
  output logic [1:0]    adr_mode_o,
  output logic          overflow_o
);
  localparam int EW = CW + PW + 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ARG1, ST_ARG2, ST_SKIP1} state_t;

  logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic          sck_prev_q, sck_prev_d;
  logic [6:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_dc_q, byte_dc_d, byte_vld_q, byte_vld_d;
  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d, arg_q, arg_d;
  logic          disp_on_q, disp_on_d, inverse_q, inverse_d, entire_on_q, entire_on_d;
  logic          flip_x_q, flip_x_d, flip_y_q, flip_y_d, overflow_q, overflow_d;
  logic [1:0]    adr_mode_q, adr_mode_d;
  logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          cs_s, sck_s, sdi_s, dc_s, sck_rise;
  logic          col_at_wrap, page_at_wrap, push_req, do_push, pop, fifo_full;
  logic [CW-1:0] col_nxt;
  logic [PW-1:0] page_nxt;
  logic [7:0]    col8;

  assign {cs_s, sck_s, sdi_s, dc_s} = sync2_q;
  assign sck_rise = sck_s & ~sck_prev_q;

  // A range wraps at its end, or at the display edge when end < start.
  assign col_at_wrap  = (col_q == col_end_q) || (col_q == CW'(DISP_WIDTH - 1));
  assign col_nxt      = col_at_wrap ? col_start_q : col_q + CW'(1);
  assign page_at_wrap = (page_q == page_end_q) || (page_q == PW'(PAGES - 1));
  assign page_nxt     = page_at_wrap ? page_start_q : page_q + PW'(1);
  assign col8         = 8'(col_q);

  assign fifo_full = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop       = (count_q != '0) && wr_ready_i;

  always_comb begin
    sync1_d    = {cs_in, sck_i, sdi_i, dc_i};
    sync2_d    = sync1_q;
    sck_prev_d = sck_s;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_d     = byte_q;
    byte_dc_d  = byte_dc_q;
    byte_vld_d = 1'b0;
    if (cs_s) begin
      bit_cnt_d = '0;
    end else if (sck_rise) begin
      shift_d   = {shift_q[5:0], sdi_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_d     = {shift_q, sdi_s};
        byte_dc_d  = dc_s;
        byte_vld_d = 1'b1;
      end
    end

    state_d      = state_q;
    cmd_d        = cmd_q;
    arg_d        = arg_q;
    disp_on_d    = disp_on_q;
    inverse_d    = inverse_q;
    entire_on_d  = entire_on_q;
    flip_x_d     = flip_x_q;
    flip_y_d     = flip_y_q;
    adr_mode_d   = adr_mode_q;
    col_d        = col_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_d       = page_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    push_req     = 1'b0;

    if (byte_vld_q && byte_dc_q) begin
      state_d = ST_IDLE;
      case (adr_mode_q)
        2'd0: begin
          push_req = 1'b1;
          col_d    = col_nxt;
          if (col_at_wrap) page_d = page_nxt;
        end
        2'd1: begin
          push_req = 1'b1;
          page_d   = page_nxt;
          if (page_at_wrap) col_d = col_nxt;
        end
        2'd2: begin
          push_req = 1'b1;
          col_d    = (col_q == CW'(DISP_WIDTH - 1)) ? '0 : col_q + CW'(1);
        end
        default: ;
      endcase
    end else if (byte_vld_q) begin
      case (state_q)
        ST_IDLE: begin
          casez (byte_q)
            8'hA4, 8'hA5: entire_on_d = byte_q[0];
            8'hA6, 8'hA7: inverse_d   = byte_q[0];
            8'hAE, 8'hAF: disp_on_d   = byte_q[0];
            8'hA0, 8'hA1: flip_x_d    = byte_q[0];
            8'hC0:        flip_y_d    = 1'b0;
            8'hC8:        flip_y_d    = 1'b1;
            8'b1011_0???: page_d      = PW'(int'(byte_q[2:0]) % PAGES);
            8'b0000_????: col_d       = CW'({col8[7:4], byte_q[3:0]});
            8'b0001_????: col_d       = CW'({byte_q[3:0], col8[3:0]});
            8'h20, 8'h21, 8'h22: begin
              cmd_d   = byte_q;
              state_d = ST_ARG1;
            end
            8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: state_d = ST_SKIP1;
            default: ;
          endcase
        end
        ST_ARG1: begin
          if (cmd_q == 8'h20) begin
            adr_mode_d = byte_q[1:0];
            state_d    = ST_IDLE;
          end else begin
            arg_d   = byte_q;
            state_d = ST_ARG2;
          end
        end
        ST_ARG2: begin
          if (cmd_q == 8'h21) begin
            col_start_d = CW'(arg_q);
            col_end_d   = CW'(byte_q);
            col_d       = CW'(arg_q);
          end else begin
            page_start_d = PW'(arg_q);
            page_end_d   = PW'(byte_q);
            page_d       = PW'(arg_q);
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push    = push_req && (!fifo_full || pop);
    overflow_d = overflow_q || (push_req && !do_push);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = {col_q, page_q, byte_q};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      sync1_q      <= 4'b1000;
      sync2_q      <= 4'b1000;
      sck_prev_q   <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      byte_q       <= '0;
      byte_dc_q    <= 1'b0;
      byte_vld_q   <= 1'b0;
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      arg_q        <= '0;
      disp_on_q    <= 1'b0;
      inverse_q    <= 1'b0;
      entire_on_q  <= 1'b0;
      flip_x_q     <= 1'b0;
      flip_y_q     <= 1'b0;
      adr_mode_q   <= 2'd2;
      col_q        <= '0;
      col_start_q  <= '0;
      col_end_q    <= CW'(DISP_WIDTH - 1);
      page_q       <= '0;
      page_start_q <= '0;
      page_end_q   <= PW'(PAGES - 1);
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sck_prev_q   <= sck_prev_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_q       <= byte_d;
      byte_dc_q    <= byte_dc_d;
      byte_vld_q   <= byte_vld_d;
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      arg_q        <= arg_d;
      disp_on_q    <= disp_on_d;
      inverse_q    <= inverse_d;
      entire_on_q  <= entire_on_d;
      flip_x_q     <= flip_x_d;
      flip_y_q     <= flip_y_d;
      adr_mode_q   <= adr_mode_d;
      col_q        <= col_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_q       <= page_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign wr_valid_o                        = (count_q != '0);
  assign {wr_col_o, wr_page_o, wr_data_o}  = mem_q[rd_ptr_q];
  assign disp_on_o                         = disp_on_q;
  assign inverse_o                         = inverse_q;
  assign entire_on_o                       = entire_on_q;
  assign flip_x_o                          = flip_x_q;
  assign flip_y_o                          = flip_y_q;
  assign adr_mode_o                        = adr_mode_q;
  assign overflow_o                        = overflow_q;
endmodule

// File: tb/tb_ssd1306_spi4_ctrl.sv
// tb/tb_ssd1306_spi4_ctrl.sv - self-checking bench for ssd1306_spi4_ctrl
// Drives SPI bytes, checks status outputs and write events through an expected-event queue.
module tb_ssd1306_spi4_ctrl;
  localparam int W = 128;
  localparam int PAGES = 8;
  localparam int D = 4;

  typedef struct packed {
    logic [6:0] col;
    logic [2:0] page;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_in = 1'b0;
  logic cs_in = 1'b1;
  logic sck_i = 1'b0;
  logic sdi_i = 1'b0;
  logic dc_i = 1'b0;
  logic wr_valid_o;
  logic wr_ready_i = 1'b1;
  logic [6:0] wr_col_o;
  logic [2:0] wr_page_o;
  logic [7:0] wr_data_o;
  logic disp_on_o, inverse_o, entire_on_o, flip_x_o, flip_y_o, overflow_o;
  logic [1:0] adr_mode_o;

  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];
  bit prev_stall = 1'b0;
  ev_t prev_ev;

  always #5 clk = ~clk;

  ssd1306_spi4_ctrl #(.DISP_WIDTH(W), .DISP_HEIGHT(PAGES * 8), .FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_in(rst_in), .cs_in(cs_in), .sck_i(sck_i), .sdi_i(sdi_i), .dc_i(dc_i),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_col_o(wr_col_o),
    .wr_page_o(wr_page_o), .wr_data_o(wr_data_o), .disp_on_o(disp_on_o),
    .inverse_o(inverse_o), .entire_on_o(entire_on_o), .flip_x_o(flip_x_o),
    .flip_y_o(flip_y_o), .adr_mode_o(adr_mode_o), .overflow_o(overflow_o)
  );

  // Scoreboard: every accepted event is compared with the oldest expected one.
  always @(negedge clk) begin
    ev_t got, e;
    got = {wr_col_o, wr_page_o, wr_data_o};
    if (rst_in && prev_stall) begin
      checks++;
      if (got !== prev_ev) begin
        errors++;
        $display("FAIL stall_hold got %h required %h", got, prev_ev);
      end
    end
    if (rst_in && wr_valid_o && wr_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got col=%0d page=%0d data=%h", wr_col_o, wr_page_o, wr_data_o);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL event got col=%0d page=%0d data=%h required col=%0d page=%0d data=%h",
                   wr_col_o, wr_page_o, wr_data_o, e.col, e.page, e.data);
        end
      end
    end
    prev_stall = rst_in && wr_valid_o && !wr_ready_i;
    prev_ev = got;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic ev_t mk(int c, int p, int d);
    ev_t e;
    e.col = 7'(c);
    e.page = 3'(p);
    e.data = 8'(d);
    return e;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input logic dc);
    cs_in = 1'b0;
    dc_i = dc;
    tick(2);
    for (int i = 0; i < nbits; i++) begin
      sdi_i = b[7-i];
      sck_i = 1'b0;
      tick(2);
      sck_i = 1'b1;
      tick(2);
    end
    sck_i = 1'b0;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, 8, dc);
    cs_in = 1'b1;
    tick(2);
  endtask

  task automatic cmd(input logic [7:0] b);
    send_byte(b, 1'b0);
  endtask

  task automatic data(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    tick(3);
    rst_in = 1'b1;
    tick(1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || wr_valid_o) && n < 500) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || wr_valid_o) begin
      errors++;
      $display("FAIL %s_drain got pending=%0d valid=%b required pending=0 valid=0", name, exp_q.size(), wr_valid_o);
    end
  endtask

  task automatic test_reset();
    logic [8:0] got;
    do_reset();
    got = {wr_valid_o, disp_on_o, inverse_o, entire_on_o, flip_x_o, flip_y_o, adr_mode_o, overflow_o};
    checks++;
    if (got !== 9'b0_00000_10_0) begin
      errors++;
      $display("FAIL reset_state got %b required %b", got, 9'b0_00000_10_0);
    end
  endtask

  task automatic test_status();
    logic [6:0] got;
    cmd(8'hAF); cmd(8'hA7); cmd(8'hA1); cmd(8'hC8);
    tick(6);
    got = {disp_on_o, inverse_o, entire_on_o, flip_x_o, flip_y_o, adr_mode_o};
    checks++;
    if (got !== 7'b11011_10) begin
      errors++;
      $display("FAIL status got %b required %b", got, 7'b11011_10);
    end
  endtask

  task automatic test_hor_range();
    cmd(8'h20); cmd(8'h00);
    cmd(8'h21); cmd(8'h7E); cmd(8'h7F);
    cmd(8'h22); cmd(8'h06); cmd(8'h07);
    tick(6);
    checks++;
    if (adr_mode_o !== 2'd0) begin
      errors++;
      $display("FAIL hor_mode got %0d required 0", adr_mode_o);
    end
    exp_q.push_back(mk(126, 6, 8'h11));
    exp_q.push_back(mk(127, 6, 8'h12));
    exp_q.push_back(mk(126, 7, 8'h13));
    exp_q.push_back(mk(127, 7, 8'h14));
    exp_q.push_back(mk(126, 6, 8'h15));
    for (int i = 0; i < 5; i++) data(8'(8'h11 + i));
    wait_drain("hor_range");
  endtask

  task automatic test_vert_sweep();
    do_reset();
    cmd(8'h20); cmd(8'h01);
    for (int i = 0; i <= W * PAGES; i++) begin
      exp_q.push_back(mk((i / PAGES) % W, i % PAGES, i));
      data(8'(i));
    end
    wait_drain("vert_sweep");
  endtask

  task automatic test_page_mode();
    cmd(8'h20); cmd(8'h02);
    cmd(8'hB3); cmd(8'h05); cmd(8'h12);
    exp_q.push_back(mk(37, 3, 8'hAA));
    data(8'hAA);
    cmd(8'h0F); cmd(8'h17);
    exp_q.push_back(mk(127, 3, 8'h5A));
    exp_q.push_back(mk(0, 3, 8'h5B));
    data(8'h5A); data(8'h5B);
    wait_drain("page_mode");
    cmd(8'h20); cmd(8'h03);
    data(8'h77);
    tick(6);
    checks++;
    if (adr_mode_o !== 2'd3 || wr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL invalid_mode got mode=%0d valid=%b required mode=3 valid=0", adr_mode_o, wr_valid_o);
    end
    cmd(8'h20); cmd(8'h02);
  endtask

  task automatic test_overflow();
    cmd(8'h00); cmd(8'h10); cmd(8'hB2);
    wr_ready_i = 1'b0;
    for (int i = 0; i < D + 2; i++) begin
      if (i < D) exp_q.push_back(mk(i, 2, 8'h60 + i));
      data(8'(8'h60 + i));
    end
    tick(6);
    checks++;
    if (overflow_o !== 1'b1 || wr_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow got ovf=%b valid=%b required ovf=1 valid=1", overflow_o, wr_valid_o);
    end
    wr_ready_i = 1'b1;
    exp_q.push_back(mk(D + 2, 2, 8'h66));
    data(8'h66);
    wait_drain("overflow");
  endtask

  task automatic test_skip_abort();
    cmd(8'h81); cmd(8'hA5);
    tick(6);
    checks++;
    if (entire_on_o !== 1'b0) begin
      errors++;
      $display("FAIL skip_arg got entire_on=%b required 0", entire_on_o);
    end
    cmd(8'h21);
    exp_q.push_back(mk(D + 3, 2, 8'h55));
    data(8'h55);
    wait_drain("abort");
  endtask

  task automatic test_cs_abort();
    send_bits(8'h3C, 5, 1'b0);
    cs_in = 1'b1;
    tick(2);
    cmd(8'hA5);
    tick(6);
    checks++;
    if (entire_on_o !== 1'b1) begin
      errors++;
      $display("FAIL cs_abort got entire_on=%b required 1", entire_on_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] got;
    cmd(8'hAF);
    send_bits(8'hFF, 3, 1'b0);
    rst_in = 1'b0;
    tick(2);
    rst_in = 1'b1;
    tick(1);
    got = {wr_valid_o, disp_on_o, inverse_o, entire_on_o, flip_x_o, flip_y_o, adr_mode_o, overflow_o};
    checks++;
    if (got !== 9'b0_00000_10_0) begin
      errors++;
      $display("FAIL reset_mid got %b required %b", got, 9'b0_00000_10_0);
    end
    send_bits(8'hAF, 8, 1'b0);
    cs_in = 1'b1;
    tick(6);
    checks++;
    if (disp_on_o !== 1'b1 || entire_on_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_bitcnt got disp_on=%b entire_on=%b required 1 0", disp_on_o, entire_on_o);
    end
  endtask

  initial begin
    test_reset();
    test_status();
    test_hor_range();
    test_vert_sweep();
    test_page_mode();
    test_overflow();
    test_skip_abort();
    test_cs_abort();
    test_reset_mid();
    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
